aes256_ctr_xcrypt: RTL and testbench

//  CTR-mode encrypt/decrypt sequencer placed around the combinational aes256 core.
//  Per job: latches key/nonce/initial counter and forms counter blocks {nonce,ctr} on core_msg.

---
 rtl/aes256_ctr_xcrypt_if.sv | 54 +++++
 rtl/aes256_ctr_xcrypt.sv | 150 +++++++++++++++
 tb/tb_aes256_ctr_xcrypt.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes256_ctr_xcrypt_if.sv
`default_nettype none
// ============================================================================
// Module  : aes256_ctr_xcrypt_if
// Brief   : Job, data-stream and core-side signal bundle for the AES-256 CTR
//           sequencer. The slave modport is the sequencer's view; the master
//           modport is the job controller / data source / core side.
// Revision: 1.0 - initial release
// ============================================================================
interface aes256_ctr_xcrypt_if #(
  parameter int CTR_W = 32,
  parameter int LEN_W = 32
);
  // Job set-up
  logic                 start;
  logic [255:0]         key;
  logic [127-CTR_W:0]   nonce;
  logic [CTR_W-1:0]     ctr_init;
  logic [LEN_W-1:0]     num_blocks;

  // Input data stream
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_data;

  // Output data stream
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;

  // Combinational AES-256 core connection
  logic [255:0]         core_key;
  logic [127:0]         core_msg;
  logic [127:0]         core_out;

  // Status
  logic                 busy;
  logic                 done;
  logic                 ctr_wrap;

  modport slave (
    input  start, key, nonce, ctr_init, num_blocks,
    input  in_valid, in_data, out_ready, core_out,
    output in_ready, out_valid, out_data, core_key, core_msg,
    output busy, done, ctr_wrap
  );

  modport master (
    output start, key, nonce, ctr_init, num_blocks,
    output in_valid, in_data, out_ready, core_out,
    input  in_ready, out_valid, out_data, core_key, core_msg,
    input  busy, done, ctr_wrap
  );
endinterface
`default_nettype wire

// File: rtl/aes256_ctr_xcrypt.sv
`default_nettype none
// ============================================================================
// Module  : aes256_ctr_xcrypt
// Brief   : CTR-mode encrypt/decrypt sequencer around a combinational AES-256
//           core. Drives registered counter blocks {nonce,ctr} and a latched
//           key into the core and XORs each keystream block with one input
//           data block, emitting results on a valid/ready stream with a
//           1-deep output register (1 block/cycle, 1-cycle latency).
// Revision: 1.0 - initial release
// ============================================================================
module aes256_ctr_xcrypt #(
  parameter int CTR_W = 32,
  parameter int LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  aes256_ctr_xcrypt_if.slave   bus
);

  localparam int NONCE_W = 128 - CTR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [255:0]         key_q,       key_d;
  logic [NONCE_W-1:0]   nonce_q,     nonce_d;
  logic [CTR_W-1:0]     ctr_q,       ctr_d;
  logic [LEN_W-1:0]     rem_q,       rem_d;
  logic                 out_valid_q, out_valid_d;
  logic [127:0]         out_data_q,  out_data_d;
  logic                 done_q,      done_d;
  logic                 wrap_q,      wrap_d;

  logic                 in_ready_w;
  logic                 in_acc_w;
  logic                 out_acc_w;

  // Input is taken only while running and the output register is free or
  // draining this same cycle, so back-to-back traffic sees no bubble.
  assign in_ready_w = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign in_acc_w   = bus.in_valid && in_ready_w;
  assign out_acc_w  = out_valid_q && bus.out_ready;

  // Next-state and datapath update: job latch, keystream XOR, counter step.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wrap_d      = wrap_q;
    done_d      = 1'b0;

    // A consumed result frees the output register unless refilled below.
    if (out_acc_w) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_blocks != '0) begin
            key_d   = bus.key;
            nonce_d = bus.nonce;
            ctr_d   = bus.ctr_init;
            rem_d   = bus.num_blocks;
            wrap_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            // Empty job completes immediately without leaving IDLE.
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (in_acc_w) begin
          // core_out is the keystream for the counter block currently on
          // core_msg; the counter advances on the same edge.
          out_data_d  = bus.in_data ^ bus.core_out;
          out_valid_d = 1'b1;
          ctr_d       = ctr_q + CTR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
          if (&ctr_q) begin
            wrap_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (out_acc_w) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  // Core inputs come straight from flops so the only single-cycle path is
  // core -> XOR -> out_data register.
  assign bus.core_key  = key_q;
  assign bus.core_msg  = {nonce_q, ctr_q};

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.ctr_wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_aes256_ctr_xcrypt.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes256_ctr_xcrypt
// Brief   : Directed self-checking bench for the AES-256 CTR sequencer. The
//           AES core is stood in for by a table holding the SP800-38A F.5.5
//           keystream blocks plus a simple key/message mixing function for
//           all other counter blocks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes256_ctr_xcrypt;

  localparam logic [255:0] KAT_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [95:0]  KAT_NON = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
  localparam logic [31:0]  KAT_CTR = 32'hfcfdfeff;
  localparam logic [127:0] KAT_KS0 = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KAT_KS1 = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] KAT_PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KAT_PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] KAT_CT0 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] KAT_CT1 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [255:0] ALT_KEY = 256'hdeadbeef00112233445566778899aabbccddeeff0123456789abcdef02468ace;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes256_ctr_xcrypt_if #(.CTR_W(32), .LEN_W(32)) bus();

  aes256_ctr_xcrypt #(.CTR_W(32), .LEN_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stand-in for the combinational AES-256 core.
  function automatic logic [127:0] core_model(input logic [255:0] k, input logic [127:0] m);
    if (k == KAT_KEY && m == {KAT_NON, KAT_CTR})         return KAT_KS0;
    if (k == KAT_KEY && m == {KAT_NON, KAT_CTR + 32'd1}) return KAT_KS1;
    return {m[95:0], m[127:96]} ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'h5a5a_1234_a5a5_9876_0f0f_cafe_f0f0_beef;
  endfunction

  assign bus.core_out = core_model(bus.core_key, bus.core_msg);

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [127:0] pt   [0:7];
  logic [127:0] expv [0:7];
  logic [255:0] j_key;
  logic [95:0]  j_nonce;
  logic [31:0]  j_ctr;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected results from the bench's own counter sequence and core model.
  task automatic fill_exp(input int n);
    for (int i = 0; i < n; i++) begin
      expv[i] = pt[i] ^ core_model(j_key, {j_nonce, j_ctr + 32'(i)});
    end
  endtask

  // Presents a job for one cycle then scrambles the job inputs so that only
  // latched values can produce correct results. Ends on a negedge.
  task automatic start_job(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c, input logic [31:0] nb);
    @(negedge clk);
    bus.start = 1'b1; bus.key = k; bus.nonce = n; bus.ctr_init = c; bus.num_blocks = nb;
    j_key = k; j_nonce = n; j_ctr = c;
    @(negedge clk);
    bus.start = 1'b0; bus.key = ~k; bus.nonce = ~n; bus.ctr_init = ~c; bus.num_blocks = 32'd0;
  endtask

  // Streams n blocks from pt[] and checks results against expv[]. Inputs
  // are driven on negedge and handshakes evaluated 1 time unit later.
  task automatic stream(input int n, input bit stall, input bit gaps, input bit poke, input string tag);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit held = 1'b0;
    logic [127:0] held_data = '0;
    while (got < n && cyc < 200) begin
      bus.in_valid  = (sent < n) && !(gaps && (cyc % 3 == 1));
      bus.in_data   = pt[(sent < n) ? sent : 0];
      bus.out_ready = stall ? (cyc % 2 == 0) : 1'b1;
      bus.start     = poke && (cyc == 1);
      if (poke && cyc == 1) bus.key = ALT_KEY;
      #1;
      if (held) begin
        check({tag, " hold valid"}, bus.out_valid, 1'b1);
        check({tag, " hold data"}, bus.out_data, held_data);
      end
      if (poke && cyc == 2) begin
        check({tag, " core_key kept"}, bus.core_key, j_key);
        check({tag, " busy kept"}, bus.busy, 1'b1);
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        check({tag, " data"}, bus.out_data, expv[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    check({tag, " blocks out"}, got, n);
  endtask

  // After the last result: exactly one done, back to idle, nothing pending.
  task automatic finish_job(input int done_before, input string tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, " done once"}, done_cnt - done_before, 1);
    check({tag, " idle"}, bus.busy, 1'b0);
    check({tag, " no extra out"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.key = '0; bus.nonce = '0; bus.ctr_init = '0; bus.num_blocks = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst in_ready", bus.in_ready, 1'b0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_data", bus.out_data, 128'd0);
    check("rst core_key", bus.core_key, 256'd0);
    check("rst core_msg", bus.core_msg, 128'd0);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst ctr_wrap", bus.ctr_wrap, 1'b0);
    rst = 1'b0;

    // 1: SP800-38A F.5.5 known-answer, free-flowing stream
    pt[0] = KAT_PT0; pt[1] = KAT_PT1; expv[0] = KAT_CT0; expv[1] = KAT_CT1;
    d0 = done_cnt;
    start_job(KAT_KEY, KAT_NON, KAT_CTR, 32'd2);
    check("t1 busy", bus.busy, 1'b1);
    check("t1 core_msg", bus.core_msg, {KAT_NON, KAT_CTR});
    stream(2, 1'b0, 1'b0, 1'b0, "t1");
    finish_job(d0, "t1");

    // 2: same job with output stalls 1010 and input gaps
    d0 = done_cnt;
    start_job(KAT_KEY, KAT_NON, KAT_CTR, 32'd2);
    stream(2, 1'b1, 1'b1, 1'b0, "t2");
    finish_job(d0, "t2");

    // 3: counter wrap from all-ones; nonce must not be carried into
    pt[0] = 128'h00112233445566778899aabbccddeeff;
    pt[1] = 128'hffeeddccbbaa99887766554433221100;
    d0 = done_cnt;
    start_job(ALT_KEY, 96'h0123456789abcdef01234567, 32'hffffffff, 32'd2);
    check("t3 msg0", bus.core_msg, {96'h0123456789abcdef01234567, 32'hffffffff});
    check("t3 wrap0", bus.ctr_wrap, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = pt[0]; bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3 msg1", bus.core_msg, {96'h0123456789abcdef01234567, 32'h00000000});
    check("t3 wrap1", bus.ctr_wrap, 1'b1);
    check("t3 out0", bus.out_data, pt[0] ^ core_model(ALT_KEY, {96'h0123456789abcdef01234567, 32'hffffffff}));
    bus.in_data = pt[1];
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3 out1", bus.out_data, pt[1] ^ core_model(ALT_KEY, {96'h0123456789abcdef01234567, 32'h00000000}));
    check("t3 nonce", bus.core_msg[127:32], 96'h0123456789abcdef01234567);
    finish_job(d0, "t3");
    check("t3 wrap sticky", bus.ctr_wrap, 1'b1);

    // 4: zero-length job
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.num_blocks = 32'd0;
    #1;
    check("t4 busy before", bus.busy, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("t4 done", bus.done, 1'b1);
    check("t4 busy", bus.busy, 1'b0);
    check("t4 out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    check("t4 done pulse", done_cnt - d0, 1);
    check("t4 busy after", bus.busy, 1'b0);

    // 5: reset after one of four blocks, then a fresh job
    pt[0] = 128'hcafebabe_00000001_11111111_22222222;
    start_job(KAT_KEY, 96'habcdef000000000000000001, 32'hffffffff, 32'd4);
    bus.in_valid = 1'b1; bus.in_data = pt[0]; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5 pending", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 in_ready", bus.in_ready, 1'b0);
    check("t5 out_valid", bus.out_valid, 1'b0);
    check("t5 out_data", bus.out_data, 128'd0);
    check("t5 core_key", bus.core_key, 256'd0);
    check("t5 core_msg", bus.core_msg, 128'd0);
    check("t5 busy", bus.busy, 1'b0);
    check("t5 done", bus.done, 1'b0);
    check("t5 ctr_wrap", bus.ctr_wrap, 1'b0);
    rst = 1'b0; bus.out_ready = 1'b1;
    pt[0] = 128'h0f0e0d0c0b0a09080706050403020100;
    pt[1] = 128'h1f1e1d1c1b1a19181716151413121110;
    pt[2] = 128'h2f2e2d2c2b2a29282726252423222120;
    d0 = done_cnt;
    start_job(256'h1, 96'h5, 32'h10, 32'd3);
    fill_exp(3);
    stream(3, 1'b0, 1'b0, 1'b0, "t5b");
    finish_job(d0, "t5b");

    // 6: start pulse during RUN with another key is ignored
    pt[0] = 128'h01010101010101010101010101010101;
    pt[1] = 128'h02020202020202020202020202020202;
    pt[2] = 128'h03030303030303030303030303030303;
    d0 = done_cnt;
    start_job(256'h0badf00d, 96'h777, 32'h7ffffffe, 32'd3);
    fill_exp(3);
    stream(3, 1'b1, 1'b0, 1'b1, "t6");
    finish_job(d0, "t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
